// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings and payload types for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [0:0] OWN_A = 1'b0;
    localparam logic [0:0] OWN_B = 1'b1;

    localparam logic [BE_W-1:0] WE_READ = 4'b0000;

    // One memory command as presented to the shared port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   we;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester A/B and memory-side signals of the data-memory port arbiter.
interface dmem_port_arbiter_if;
    import dmem_port_arbiter_pkg::*;

    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [BE_W-1:0]   a_we;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_done;
    logic [DATA_W-1:0] a_rdata;
    logic              a_stall;

    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic [BE_W-1:0]   b_we;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_done;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view.
    modport slave (
        input  a_req, a_addr, a_we, a_wdata,
        input  b_req, b_addr, b_we, b_wdata,
        input  mem_rdata,
        output a_gnt, a_done, a_rdata, a_stall,
        output b_gnt, b_done, b_rdata,
        output mem_en, mem_addr, mem_we, mem_wdata
    );

    // Requester/memory environment view.
    modport master (
        output a_req, a_addr, a_we, a_wdata,
        output b_req, b_addr, b_we, b_wdata,
        output mem_rdata,
        input  a_gnt, a_done, a_rdata, a_stall,
        input  b_gnt, b_done, b_rdata,
        input  mem_en, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the pipeline (A) and a secondary master (B).
// One access in flight at a time; B is forced through after STARVE_MAX lost rounds.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_port_arbiter_if.slave bus
);

    localparam int unsigned STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [0:0]          state_q, state_d;
    logic [0:0]          owner_q, owner_d;
    logic                is_read_q, is_read_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                a_done_q, a_done_d;
    logic                b_done_q, b_done_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

    mem_cmd_t a_cmd, b_cmd, win_cmd;
    logic     issue, sel_b, issue_ok;

    // Byte lanes below the word boundary are the shifter's concern.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.a_addr[1:0], bus.b_addr[1:0]};

    // Word-aligned request payloads.
    always_comb begin
        a_cmd.addr  = {bus.a_addr[ADDR_W-1:2], 2'b00};
        a_cmd.we    = bus.a_we;
        a_cmd.wdata = bus.a_wdata;
        b_cmd.addr  = {bus.b_addr[ADDR_W-1:2], 2'b00};
        b_cmd.we    = bus.b_we;
        b_cmd.wdata = bus.b_wdata;
    end

    // Next-state, arbitration and completion logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        is_read_d = is_read_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        issue     = 1'b0;
        sel_b     = 1'b0;
        win_cmd   = a_cmd;

        case (state_q)
            ST_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    sel_b     = bus.b_req && (!bus.a_req || (starve_q == STARVE_W'(STARVE_MAX)));
                    win_cmd   = sel_b ? b_cmd : a_cmd;
                    issue     = 1'b1;
                    owner_d   = sel_b ? OWN_B : OWN_A;
                    is_read_d = (win_cmd.we == WE_READ);
                    cnt_d     = is_read_d ? CNT_W'(RD_LAT) : CNT_W'(1);
                    state_d   = ST_BUSY;
                end
                // B's loss streak: cleared on a B win or an idle B, saturating otherwise.
                if (!bus.b_req || sel_b) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_A) begin
                        a_done_d = 1'b1;
                        if (is_read_q) begin
                            a_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        b_done_d = 1'b1;
                        if (is_read_q) begin
                            b_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_A;
            is_read_q <= 1'b0;
            cnt_q     <= '0;
            starve_q  <= '0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            is_read_q <= is_read_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Issue-cycle drive of the memory port; quiet while reset is asserted.
    assign issue_ok      = issue && !reset;
    assign bus.mem_en    = issue_ok;
    assign bus.mem_addr  = issue_ok ? win_cmd.addr  : '0;
    assign bus.mem_we    = issue_ok ? win_cmd.we    : WE_READ;
    assign bus.mem_wdata = issue_ok ? win_cmd.wdata : '0;

    assign bus.a_gnt   = issue_ok && !sel_b;
    assign bus.b_gnt   = issue_ok && sel_b;
    assign bus.a_done  = a_done_q;
    assign bus.b_done  = b_done_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
    assign bus.a_stall = bus.a_req && !a_done_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: main instance at RD_LAT=2, plus RD_LAT=1/7 instances.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int unsigned MAIN_LAT = 2;
    localparam int          BUDGET   = 40;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_port_arbiter_if bus ();
    dmem_port_arbiter_if bus1 ();
    dmem_port_arbiter_if bus7 ();

    dmem_port_arbiter #(.RD_LAT(MAIN_LAT), .STARVE_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    dmem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    dmem_port_arbiter #(.RD_LAT(7), .STARVE_MAX(4)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

    // Memory read contents as a function of the word address.
    function automatic logic [31:0] rd_pat(input logic [31:0] wa);
        return (wa == 32'h0000_1004) ? 32'hDEAD_BEEF : (wa ^ 32'h5A5A_A5A5);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory models: read data appears exactly L cycles after mem_en, filler otherwise.
    logic [31:0] pipe2 [2];
    logic [31:0] pipe1 [1];
    logic [31:0] pipe7 [7];

    always @(posedge clk) begin
        for (int i = 1; i > 0; i--) pipe2[i] <= pipe2[i-1];
        pipe2[0] <= (bus.mem_en && bus.mem_we == 4'b0) ? rd_pat(bus.mem_addr) : {16'hBAD2, cyc[15:0]};
        pipe1[0] <= (bus1.mem_en && bus1.mem_we == 4'b0) ? rd_pat(bus1.mem_addr) : {16'hBAD1, cyc[15:0]};
        for (int i = 6; i > 0; i--) pipe7[i] <= pipe7[i-1];
        pipe7[0] <= (bus7.mem_en && bus7.mem_we == 4'b0) ? rd_pat(bus7.mem_addr) : {16'hBAD7, cyc[15:0]};
    end

    assign bus.mem_rdata  = pipe2[1];
    assign bus1.mem_rdata = pipe1[0];
    assign bus7.mem_rdata = pipe7[6];

    // Latency-sweep instances: A only.
    logic        l_req  [2];
    logic [31:0] l_addr [2];
    assign bus1.a_req = l_req[0];  assign bus1.a_addr = l_addr[0];
    assign bus1.a_we  = 4'b0;      assign bus1.a_wdata = 32'h0;
    assign bus1.b_req = 1'b0;      assign bus1.b_addr = 32'h0;
    assign bus1.b_we  = 4'b0;      assign bus1.b_wdata = 32'h0;
    assign bus7.a_req = l_req[1];  assign bus7.a_addr = l_addr[1];
    assign bus7.a_we  = 4'b0;      assign bus7.a_wdata = 32'h0;
    assign bus7.b_req = 1'b0;      assign bus7.b_addr = 32'h0;
    assign bus7.b_we  = 4'b0;      assign bus7.b_wdata = 32'h0;

    // Scoreboard: expected rdata per completion, plus grant order log.
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;
    logic [7:0]  glog [$];
    int          a_evt = 0;

    always @(negedge clk) begin
        if (bus.a_gnt === 1'b1) glog.push_back(8'h41);
        if (bus.b_gnt === 1'b1) glog.push_back(8'h42);
        if (bus.a_gnt === 1'b1 || bus.a_done === 1'b1) a_evt <= a_evt + 1;
        if (bus.a_done === 1'b1) begin
            if (exp_a.size() == 0) check("a_done_unexpected", 32'h1, 32'h0);
            else check("a_rdata", bus.a_rdata, exp_a.pop_front());
        end
        if (bus.b_done === 1'b1) begin
            if (exp_b.size() == 0) check("b_done_unexpected", 32'h1, 32'h0);
            else check("b_rdata", bus.b_rdata, exp_b.pop_front());
        end
    end

    // One access on the main instance; returns grant and done cycles.
    task automatic do_access(input bit is_b, input logic [31:0] addr, input logic [3:0] we,
                             input logic [31:0] wd, output int t_gnt, output int t_done);
        logic [31:0] wa;
        bit got;
        wa = {addr[31:2], 2'b00};
        t_gnt = -1;
        t_done = -1;
        if (!is_b) begin
            bus.a_addr = addr; bus.a_we = we; bus.a_wdata = wd; bus.a_req = 1'b1;
            if (we == 4'b0) last_a = rd_pat(wa);
            exp_a.push_back(last_a);
        end else begin
            bus.b_addr = addr; bus.b_we = we; bus.b_wdata = wd; bus.b_req = 1'b1;
            if (we == 4'b0) last_b = rd_pat(wa);
            exp_b.push_back(last_b);
        end
        got = 1'b0;
        for (int n = 0; n < BUDGET && !got; n++) begin
            #1;
            if ((is_b ? bus.b_gnt : bus.a_gnt) === 1'b1) begin
                got = 1'b1;
                t_gnt = cyc;
                check("mem_en", 32'(bus.mem_en), 32'h1);
                check("mem_addr", bus.mem_addr, wa);
                check("mem_we", 32'(bus.mem_we), 32'(we));
                check("mem_wdata", bus.mem_wdata, wd);
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            check(is_b ? "b_gnt_timeout" : "a_gnt_timeout", 32'h0, 32'h1);
        end else begin
            check("mem_en_busy", 32'(bus.mem_en), 32'h0);
            for (int n = 0; n < BUDGET && t_done < 0; n++) begin
                if ((is_b ? bus.b_done : bus.a_done) === 1'b1) begin
                    t_done = cyc;
                end else begin
                    if (!is_b) check("a_stall_wait", 32'(bus.a_stall), 32'h1);
                    @(posedge clk); #1;
                end
            end
            if (t_done < 0) begin
                check(is_b ? "b_done_timeout" : "a_done_timeout", 32'h0, 32'h1);
            end else begin
                check("latency", 32'(t_done - t_gnt), (we == 4'b0) ? 32'(MAIN_LAT + 1) : 32'h2);
                if (!is_b) check("a_stall_done", 32'(bus.a_stall), 32'h0);
            end
        end
        if (!is_b) bus.a_req = 1'b0;
        else bus.b_req = 1'b0;
    endtask

    // Single read on a latency-sweep instance.
    task automatic lat_read(input int idx, input logic [31:0] addr, input int lat);
        int tg;
        int td;
        logic [31:0] rd;
        tg = -1;
        td = -1;
        rd = 32'h0;
        l_addr[idx] = addr;
        l_req[idx] = 1'b1;
        for (int n = 0; n < BUDGET && tg < 0; n++) begin
            #1;
            if ((idx == 0 ? bus1.a_gnt : bus7.a_gnt) === 1'b1) tg = cyc;
            @(posedge clk); #1;
        end
        l_req[idx] = 1'b0;
        for (int n = 0; n < BUDGET && td < 0; n++) begin
            if ((idx == 0 ? bus1.a_done : bus7.a_done) === 1'b1) begin
                td = cyc;
                rd = (idx == 0) ? bus1.a_rdata : bus7.a_rdata;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("lat_gnt_seen", 32'(tg >= 0), 32'h1);
        check("lat_done_cycle", 32'(td - tg), 32'(lat + 1));
        check("lat_rdata", rd, rd_pat({addr[31:2], 2'b00}));
    endtask

    initial begin
        int g1, d1, g2, d2, t0, evt0;
        string exp_order;
        bus.a_req = 1'b1; bus.a_addr = 32'h0; bus.a_we = 4'b0; bus.a_wdata = 32'h0;
        bus.b_req = 1'b1; bus.b_addr = 32'h0; bus.b_we = 4'b0; bus.b_wdata = 32'h0;
        l_req[0] = 1'b0; l_req[1] = 1'b0; l_addr[0] = 32'h0; l_addr[1] = 32'h0;

        // Reset with both requests pending: nothing issues.
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", 32'(bus.mem_en), 32'h0);
        check("rst_a_gnt", 32'(bus.a_gnt), 32'h0);
        check("rst_b_gnt", 32'(bus.b_gnt), 32'h0);
        check("rst_a_done", 32'(bus.a_done), 32'h0);
        check("rst_b_done", 32'(bus.b_done), 32'h0);
        check("rst_a_rdata", bus.a_rdata, 32'h0);
        check("rst_b_rdata", bus.b_rdata, 32'h0);
        check("rst_a_stall", 32'(bus.a_stall), 32'h1);
        bus.a_req = 1'b0; bus.b_req = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        check("idle_mem_en", 32'(bus.mem_en), 32'h0);
        check("idle_mem_we", 32'(bus.mem_we), 32'h0);

        // B alone: read then write back to back, A untouched.
        evt0 = a_evt;
        do_access(1'b1, 32'h0000_2204, 4'b0000, 32'h0, g1, d1);
        do_access(1'b1, 32'h0000_2208, 4'b1111, 32'h1234_5678, g2, d2);
        check("b_back_to_back", 32'(g2), 32'(d1));
        @(posedge clk); #1;
        check("b_done_pulse", 32'(bus.b_done), 32'h0);
        check("a_quiet", 32'(a_evt - evt0), 32'h0);
        check("a_rdata_quiet", bus.a_rdata, 32'h0);

        // A read of an unaligned address, then a partial write.
        do_access(1'b0, 32'h0000_1006, 4'b0000, 32'h0, g1, d1);
        check("a_rdata_direct", bus.a_rdata, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h0000_1010, 4'b0011, 32'h0000_ABCD, g1, d1);
        @(posedge clk); #1;
        check("a_done_pulse", 32'(bus.a_done), 32'h0);
        check("a_rdata_after_wr", bus.a_rdata, 32'hDEAD_BEEF);

        // Both requesting continuously: B forced through every fifth grant.
        glog.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) do_access(1'b0, 32'h0000_3000 + 32'(i * 4), 4'b0, 32'h0, g1, d1);
            end
            begin
                for (int i = 0; i < 2; i++) do_access(1'b1, 32'h0000_3800 + 32'(i * 4), 4'b0, 32'h0, g2, d2);
            end
        join
        @(posedge clk); #1;
        exp_order = "AAAABAAAAB";
        check("grant_count", 32'(glog.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check("grant_order", (i < glog.size()) ? 32'(glog[i]) : 32'h0, 32'(exp_order[i]));
        end

        // Reset in the cycle after an A read issues.
        bus.a_addr = 32'h0000_4008; bus.a_we = 4'b0; bus.a_req = 1'b1;
        t0 = cyc;
        #1;
        check("rst_mid_gnt", 32'(bus.a_gnt), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1; bus.a_req = 1'b0;
        #1;
        check("rst_mid_mem_en", 32'(bus.mem_en), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_a = 32'h0;
        check("rst_mid_a_done", 32'(bus.a_done), 32'h0);
        check("rst_mid_a_rdata", bus.a_rdata, 32'h0);
        do_access(1'b0, 32'h0000_5000, 4'b0000, 32'h0, g1, d1);
        check("rst_regrant", 32'(g1), 32'(t0 + 2));

        // Latency sweep.
        lat_read(0, 32'h0000_6002, 1);
        lat_read(1, 32'h0000_7004, 7);

        repeat (4) @(posedge clk);
        check("a_queue_empty", 32'(exp_a.size()), 32'h0);
        check("b_queue_empty", 32'(exp_b.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
        $fatal(1);
    end

endmodule
